// File: rtl/n1_sbram.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// n1_sbram
// Stack-bus to single-port RAM bridge for the N1 processor.
//
// A pipelined-wishbone target serving two stack regions, the parameter stack
// (PS) and the return stack (RS), out of one synchronous single-port RAM. The
// PS occupies RAM words [0, PS_DEPTH) and the RS the words that follow it.
// Every accepted access runs IDLE -> CMD -> RESP, or -> ERR when illegal, so
// the peak throughput is one access every two cycles.
//
// Ports
//   clk_i, async_rst_i      clock; asynchronous active-low reset
//   sbus_cyc_i/stb_i/we_i   stack bus cycle, strobe and write enable
//   sbus_adr_i, sbus_dat_i  stack-relative word address and write data
//   sbus_tga_ps_i/_rs_i     PS / RS select tags (exactly one must be set)
//   sbus_ack_o/err_o/rty_o  target responses (rty is never used)
//   sbus_stall_o            back-pressure, high only while the RAM is busy
//   sbus_dat_o              read data, zero outside a response cycle
//   ram_en_o, ram_we_o      RAM enable / write enable
//   ram_adr_o, ram_dat_o    RAM word address / write data
//   ram_dat_i               RAM read data, valid the cycle after a grant
//   ram_gnt_i               RAM accepts the presented access this cycle
//   prb_sbram_state_o       FSM state probe
// -----------------------------------------------------------------------------
module n1_sbram #(
  parameter int SP_WIDTH = 12,
  parameter int PS_DEPTH = 1024,
  parameter int RS_DEPTH = 1024,
  parameter int RAM_AW   = 11
) (
  input  logic                clk_i,
  input  logic                async_rst_i,
  // stack bus
  input  logic                sbus_cyc_i,
  input  logic                sbus_stb_i,
  input  logic                sbus_we_i,
  input  logic [SP_WIDTH-1:0] sbus_adr_i,
  input  logic [15:0]         sbus_dat_i,
  input  logic                sbus_tga_ps_i,
  input  logic                sbus_tga_rs_i,
  output logic                sbus_ack_o,
  output logic                sbus_err_o,
  output logic                sbus_rty_o,
  output logic                sbus_stall_o,
  output logic [15:0]         sbus_dat_o,
  // RAM port
  output logic                ram_en_o,
  output logic                ram_we_o,
  output logic [RAM_AW-1:0]   ram_adr_o,
  output logic [15:0]         ram_dat_o,
  input  logic [15:0]         ram_dat_i,
  input  logic                ram_gnt_i,
  // probe
  output logic [1:0]          prb_sbram_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMD  = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  // Region limits carry one extra bit so a depth of exactly 2**SP_WIDTH
  // still compares correctly against every possible address.
  localparam logic [SP_WIDTH:0] PS_LIMIT = (SP_WIDTH+1)'(PS_DEPTH);
  localparam logic [SP_WIDTH:0] RS_LIMIT = (SP_WIDTH+1)'(RS_DEPTH);
  localparam logic [RAM_AW-1:0] RS_BASE  = RAM_AW'(PS_DEPTH);

  state_t state_q, state_d;

  // Holding register. The RAM address is stored already mapped, so the
  // region tag itself does not need to be kept.
  logic              hold_we_q;
  logic [RAM_AW-1:0] hold_adr_q;
  logic [15:0]       hold_dat_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic              ps_sel;
  logic              rs_sel;
  logic [SP_WIDTH:0] adr_ext;
  logic              req_legal;
  logic              req_accept;
  logic [RAM_AW-1:0] req_ram_adr;

  assign ps_sel  = sbus_tga_ps_i & ~sbus_tga_rs_i;
  assign rs_sel  = sbus_tga_rs_i & ~sbus_tga_ps_i;
  assign adr_ext = {1'b0, sbus_adr_i};

  // Both-tags and no-tag requests fall through as illegal.
  assign req_legal = (ps_sel && (adr_ext < PS_LIMIT)) ||
                     (rs_sel && (adr_ext < RS_LIMIT));

  assign req_accept = sbus_cyc_i & sbus_stb_i & ~sbus_stall_o;

  // RS words sit directly above the PS region; the sum wraps at RAM_AW bits.
  assign req_ram_adr = RAM_AW'(sbus_adr_i) + (rs_sel ? RS_BASE : '0);

  // ---------------------------------------------------------------------------
  // State and holding register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the holding register is a handful of flops, not a memory array, so
  // it is cleared on reset; a stale address can never reach the RAM because
  // the RAM outputs are gated by the CMD state anyway.
  always_ff @(posedge clk_i or negedge async_rst_i) begin
    if (!async_rst_i) begin
      hold_we_q  <= 1'b0;
      hold_adr_q <= '0;
      hold_dat_q <= '0;
    end else if (req_accept && req_legal) begin
      hold_we_q  <= sbus_we_i;
      hold_adr_q <= req_ram_adr;
      hold_dat_q <= sbus_dat_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  // NOTE: state_d is given a default before the case so no path through the
  // block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CMD: begin
        if (!sbus_cyc_i) begin
          state_d = ST_IDLE;          // master abandoned the cycle
        end else if (ram_gnt_i) begin
          state_d = ST_RESP;
        end
      end
      // IDLE, RESP and ERR are all open for a new request; RESP and ERR are
      // single-cycle and fall back to IDLE when nothing new arrives.
      default: begin
        if (req_accept) begin
          state_d = req_legal ? ST_CMD : ST_ERR;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Everything is decoded from the state register, so an asynchronous reset
  // drops all outputs to zero without waiting for a clock edge.
  always_comb begin
    sbus_ack_o   = 1'b0;
    sbus_err_o   = 1'b0;
    sbus_stall_o = 1'b0;
    sbus_dat_o   = 16'h0000;
    ram_en_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_adr_o    = '0;
    ram_dat_o    = 16'h0000;
    unique case (state_q)
      ST_CMD: begin
        sbus_stall_o = 1'b1;
        // Without cyc the access is being aborted, so the RAM is left alone.
        if (sbus_cyc_i) begin
          ram_en_o  = 1'b1;
          ram_we_o  = hold_we_q;
          ram_adr_o = hold_adr_q;
          ram_dat_o = hold_dat_q;
        end
      end
      ST_RESP: begin
        sbus_ack_o = sbus_cyc_i;
        sbus_dat_o = hold_we_q ? 16'h0000 : ram_dat_i;
      end
      ST_ERR: begin
        sbus_err_o = sbus_cyc_i;
      end
      default: begin
      end
    endcase
  end

  assign sbus_rty_o        = 1'b0;
  assign prb_sbram_state_o = state_q;

endmodule
